packet_handler_hls_deadlock_confirm_unit: RTL and testbench
===========================================================

# packet_handler_hls_deadlock_confirm_unit

Per-process deadlock detector with temporal confirmation. It merges dependence vectors from upstream channels and forwards its own vector downstream, as the existing per-process units do. A self-dependence must persist for a programmable number of cycles before a deadlock is reported. It also latches the blocked-channel snapshot, holds a sticky confirmation flag, and propagates the report token. One instance sits beside each dataflow process in the packet_handler deadlock-detection network.

## Interface
- PROC_NUM, 4, processes in the network (dependence vector width)
- PROC_ID, 0, index of this process (0..PROC_NUM-1)
- IN_CHAN_NUM, 2, incoming dependence channels
- OUT_CHAN_NUM, 3, outgoing dependence channels
- CONFIRM_CYCLES, 16, consecutive qualifying cycles required before a report (>=1)
- CNT_W, $clog2(CONFIRM_CYCLES+1), derived localparam, not overridable
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- proc_dep_vld_vec  in  OUT_CHAN_NUM  process blocked on output channel i
- in_chan_dep_vld_vec  in  IN_CHAN_NUM  upstream dependence valid
- in_chan_dep_data_vec  in  IN_CHAN_NUM*PROC_NUM  upstream dependence vectors, channel i at [i*PROC_NUM +: PROC_NUM]
- token_in_vec  in  IN_CHAN_NUM  report token from upstream
- dl_detect_in  in  1  global deadlock already flagged
- origin  in  1  this unit originates the token
- token_clear  in  1  kill token propagation
- out_chan_dep_vld_vec  out  OUT_CHAN_NUM  equals proc_dep_vld_vec (combinational)
- out_chan_dep_data  out  PROC_NUM  dep_reg OR onehot(PROC_ID)
- token_out_vec  out  OUT_CHAN_NUM  registered token
- dl_detect_out  out  1  one-cycle registered report pulse
- dl_confirmed  out  1  sticky; cleared only by reset
- blocked_chan_vec  out  OUT_CHAN_NUM  proc_dep_vld_vec captured at report
- stall_cnt  out  CNT_W  current qualifying-cycle count

## Operation
- merged = OR over i of (in_chan_dep_data_vec[i] masked by in_chan_dep_vld_vec[i]).
- gate = ~dl_detect_in | (|token_in_vec). dep = gate ? merged : dep_reg.
- dep_reg <= (|proc_dep_vld_vec) ? dep : 0.
- cond = gate & dep[PROC_ID] & (|proc_dep_vld_vec).
- FSM states:
  - IDLE: if cond, cnt<=1 and go to REPORT if CONFIRM_CYCLES==1, else to CONFIRM.
  - CONFIRM: if cond, cnt<=cnt+1 and go to REPORT when cnt+1==CONFIRM_CYCLES. If ~cond, cnt<=0 and go to IDLE.
  - REPORT: lasts one cycle. dl_detect_out=1. Set dl_confirmed. Latch blocked_chan_vec from proc_dep_vld_vec in this cycle. Go to HOLD.
  - HOLD: cnt frozen. When ~|proc_dep_vld_vec, cnt<=0 and go to IDLE.
- A re-report from HOLD requires leaving to IDLE and a fresh full confirmation.
- Token: token_out_vec <= ((|token_in_vec & ~token_clear) | origin) ? proc_dep_vld_vec : 0. origin overrides token_clear.
- cnt never exceeds CONFIRM_CYCLES (no wrap).

## Timing
- Reset values: dep_reg=0, FSM=IDLE, cnt=0, token_out_vec=0, dl_detect_out=0, dl_confirmed=0, blocked_chan_vec=0.
- Combinational outputs while reset is asserted: out_chan_dep_vld_vec follows proc_dep_vld_vec. out_chan_dep_data = onehot(PROC_ID).
- Report latency: cond is true in cycles 0..CONFIRM_CYCLES-1, and dl_detect_out is high in cycle CONFIRM_CYCLES. Minimum latency 1 cycle.
- A single false cycle of cond in CONFIRM restarts counting from 0.
- Reset asserted mid-CONFIRM or mid-HOLD returns immediately to the reset values. dl_confirmed is lost.
- dl_detect_in rising while in CONFIRM with no token: dep freezes to dep_reg, but cond is 0, so the FSM falls to IDLE.
- token_out_vec lags token_in_vec/origin by one cycle.

## Configuration
- PACKET_HANDLER_DL_TRACE_EN defined:
  - Adds a 32-bit free-running cycle stamp (reset 0, wraps) and output ports trace_vld (1), trace_dep (PROC_NUM) and trace_stamp (32).
  - In the REPORT cycle: trace_dep<=dep and trace_stamp<=stamp, both registered and held. trace_vld pulses one cycle after REPORT.
- Undefined: trace ports and stamp counter are absent. All other behaviour is identical.

## Structure
- Package packet_handler_dl_pkg holds:
  - FSM state typedef: IDLE=2'b00, CONFIRM=2'b01, REPORT=2'b10, HOLD=2'b11.
  - onehot function.
  - TRACE_STAMP_W=32.
- Sub-module packet_handler_dl_dep_merge: parametrised masked OR reduction producing merged. The FSM, counter and token logic stay in the top module.

## Test plan
- PROC_ID=0, CONFIRM_CYCLES=4, in_chan_dep_vld_vec=2'b01 with data 4'b0001, proc_dep_vld_vec=3'b010 held -> dl_detect_out pulses in cycle 4 only, dl_confirmed=1, blocked_chan_vec=3'b010, stall_cnt=4.
- Same stimulus, but in_chan_dep_vld_vec drops to 0 in cycle 2 for one cycle -> stall_cnt returns to 0, and the report arrives only after 4 further consecutive qualifying cycles.
- CONFIRM_CYCLES=1 -> report in the cycle after the first qualifying cycle. The CONFIRM state is never entered.
- dl_detect_in=1, token_in_vec=0, upstream data changes -> out_chan_dep_data keeps the previous dep_reg value. No report.
- token_in_vec=2'b10 with token_clear=1 -> token_out_vec=0. origin=1 with token_clear=1 -> token_out_vec=proc_dep_vld_vec next cycle.
- Reset pulse in HOLD -> all outputs return to reset values. With PACKET_HANDLER_DL_TRACE_EN: trace_stamp equals the stamp at REPORT, and trace_vld is one pulse.

Source files
------------

// File: rtl/packet_handler_dl_pkg.sv
// Shared types and helpers for the packet_handler deadlock-detection units.
// FSM encoding, onehot helper and trace stamp width.
package packet_handler_dl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONFIRM = 2'b01,
    REPORT  = 2'b10,
    HOLD    = 2'b11
  } dl_state_e;

  localparam int TRACE_STAMP_W = 32;
  localparam int ONEHOT_W = 64;

  function automatic logic [ONEHOT_W-1:0] onehot(input int idx);
    onehot = {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/packet_handler_dl_dep_merge.sv
// Masked OR reduction of upstream dependence vectors.
// Channel i occupies bits [i*PROC_NUM +: PROC_NUM] of data.
module packet_handler_dl_dep_merge #(
  parameter int PROC_NUM    = 4,
  parameter int IN_CHAN_NUM = 2
) (
  input  logic [IN_CHAN_NUM-1:0]          vld,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] data,
  output logic [PROC_NUM-1:0]             merged
);

  always_comb begin
    merged = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      merged = merged | (data[i*PROC_NUM +: PROC_NUM] & {PROC_NUM{vld[i]}});
    end
  end

endmodule

// File: rtl/packet_handler_hls_deadlock_confirm_unit.sv
// Per-process deadlock detector with temporal confirmation of self-dependence.
// Optional report trace (stamp, dep snapshot) under PACKET_HANDLER_DL_TRACE_EN.
module packet_handler_hls_deadlock_confirm_unit
  import packet_handler_dl_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int CONFIRM_CYCLES = 16,
  localparam int CNT_W         = $clog2(CONFIRM_CYCLES + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic                            dl_confirmed,
  output logic [OUT_CHAN_NUM-1:0]         blocked_chan_vec,
  output logic [CNT_W-1:0]                stall_cnt
`ifdef PACKET_HANDLER_DL_TRACE_EN
  ,
  output logic                            trace_vld,
  output logic [PROC_NUM-1:0]             trace_dep,
  output logic [TRACE_STAMP_W-1:0]        trace_stamp
`endif
);

  localparam logic [ONEHOT_W-1:0] SELF_W = onehot(PROC_ID);
  localparam logic [PROC_NUM-1:0] SELF = SELF_W[PROC_NUM-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dl_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [PROC_NUM-1:0] dep_reg;
  logic [PROC_NUM-1:0] merged;
  logic [PROC_NUM-1:0] dep;
  logic                gate;
  logic                busy;
  logic                cond;
  logic                tok_fwd;

  packet_handler_dl_dep_merge #(
    .PROC_NUM    (PROC_NUM),
    .IN_CHAN_NUM (IN_CHAN_NUM)
  ) u_merge (
    .vld    (in_chan_dep_vld_vec),
    .data   (in_chan_dep_data_vec),
    .merged (merged)
  );

  // once a deadlock is flagged globally, only token holders see fresh deps
  always_comb begin
    gate    = ~dl_detect_in | (|token_in_vec);
    dep     = gate ? merged : dep_reg;
    busy    = |proc_dep_vld_vec;
    cond    = gate & dep[PROC_ID] & busy;
    tok_fwd = ((|token_in_vec) & ~token_clear) | origin;
    cnt_inc = cnt + CNT_ONE;
  end

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg | SELF;
  assign stall_cnt            = cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      dep_reg          <= '0;
      token_out_vec    <= '0;
      dl_detect_out    <= 1'b0;
      dl_confirmed     <= 1'b0;
      blocked_chan_vec <= '0;
    end else begin
      dep_reg       <= busy ? dep : '0;
      token_out_vec <= tok_fwd ? proc_dep_vld_vec : '0;
      dl_detect_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cond) begin
            cnt <= CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              state         <= REPORT;
              dl_detect_out <= 1'b1;
              dl_confirmed  <= 1'b1;
            end else begin
              state <= CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (cond) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state         <= REPORT;
              dl_detect_out <= 1'b1;
              dl_confirmed  <= 1'b1;
            end
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        REPORT: begin
          blocked_chan_vec <= proc_dep_vld_vec;
          state            <= HOLD;
        end
        HOLD: begin
          if (!busy) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PACKET_HANDLER_DL_TRACE_EN
  logic [TRACE_STAMP_W-1:0] stamp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stamp       <= '0;
      trace_vld   <= 1'b0;
      trace_dep   <= '0;
      trace_stamp <= '0;
    end else begin
      stamp     <= stamp + 1'b1;
      trace_vld <= (state == REPORT);
      if (state == REPORT) begin
        trace_dep   <= dep;
        trace_stamp <= stamp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_handler_hls_deadlock_confirm_unit.sv
// Scoreboard bench: two DUTs (CONFIRM_CYCLES 4 and 1) against a cycle model.
// Trace ports are checked when PACKET_HANDLER_DL_TRACE_EN is defined.
module tb_packet_handler_hls_deadlock_confirm_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] proc = '0;
  logic [1:0] ivld = '0;
  logic [7:0] idata = '0;
  logic [1:0] tin = '0;
  logic       dli = 1'b0;
  logic       org = 1'b0;
  logic       tclr = 1'b0;

  logic [2:0] o_vld [2];
  logic [3:0] o_data [2];
  logic [2:0] o_tok [2];
  logic       o_det [2];
  logic       o_conf [2];
  logic [2:0] o_blk [2];
  logic [2:0] cnt_a;
  logic [0:0] cnt_b;
`ifdef PACKET_HANDLER_DL_TRACE_EN
  logic        t_vld [2];
  logic [3:0]  t_dep [2];
  logic [31:0] t_stamp [2];
`endif

  always #5 clock = ~clock;

  packet_handler_hls_deadlock_confirm_unit #(
    .PROC_NUM(4), .PROC_ID(0), .IN_CHAN_NUM(2),
    .OUT_CHAN_NUM(3), .CONFIRM_CYCLES(4)
  ) dut_a (
    .clock(clock), .reset(reset),
    .proc_dep_vld_vec(proc), .in_chan_dep_vld_vec(ivld),
    .in_chan_dep_data_vec(idata), .token_in_vec(tin),
    .dl_detect_in(dli), .origin(org), .token_clear(tclr),
    .out_chan_dep_vld_vec(o_vld[0]), .out_chan_dep_data(o_data[0]),
    .token_out_vec(o_tok[0]), .dl_detect_out(o_det[0]),
    .dl_confirmed(o_conf[0]), .blocked_chan_vec(o_blk[0]),
    .stall_cnt(cnt_a)
`ifdef PACKET_HANDLER_DL_TRACE_EN
    , .trace_vld(t_vld[0]), .trace_dep(t_dep[0]),
    .trace_stamp(t_stamp[0])
`endif
  );

  packet_handler_hls_deadlock_confirm_unit #(
    .PROC_NUM(4), .PROC_ID(0), .IN_CHAN_NUM(2),
    .OUT_CHAN_NUM(3), .CONFIRM_CYCLES(1)
  ) dut_b (
    .clock(clock), .reset(reset),
    .proc_dep_vld_vec(proc), .in_chan_dep_vld_vec(ivld),
    .in_chan_dep_data_vec(idata), .token_in_vec(tin),
    .dl_detect_in(dli), .origin(org), .token_clear(tclr),
    .out_chan_dep_vld_vec(o_vld[1]), .out_chan_dep_data(o_data[1]),
    .token_out_vec(o_tok[1]), .dl_detect_out(o_det[1]),
    .dl_confirmed(o_conf[1]), .blocked_chan_vec(o_blk[1]),
    .stall_cnt(cnt_b)
`ifdef PACKET_HANDLER_DL_TRACE_EN
    , .trace_vld(t_vld[1]), .trace_dep(t_dep[1]),
    .trace_stamp(t_stamp[1])
`endif
  );

  typedef struct {
    logic [3:0]  dep_r;
    int          run;
    bit          pulse;
    bit          hold;
    bit          conf;
    logic [2:0]  blk;
    logic [2:0]  tok;
    logic [31:0] stamp;
    bit          tv;
    logic [3:0]  td;
    logic [31:0] ts;
  } mdl_t;

  typedef struct {
    int          idx;
    logic [2:0]  vld;
    logic [3:0]  data;
    logic [2:0]  tok;
    bit          det;
    bit          conf;
    logic [2:0]  blk;
    int          cnt;
    bit          tv;
    logic [3:0]  td;
    logic [31:0] ts;
  } exp_t;

  mdl_t m [2];
  int   ccv [2] = '{4, 1};
  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;
  int   reports = 0;

  task automatic chk(string name, int idx, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d act=%0d exp=%0d t=%0t",
               name, idx, act, exp, $time);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t r;
    r.dep_r = '0; r.run = 0; r.pulse = 0; r.hold = 0;
    r.conf = 0; r.blk = '0; r.tok = '0; r.stamp = '0;
    r.tv = 0; r.td = '0; r.ts = '0;
    return r;
  endfunction

  // one cycle of the behavioural model: emit current outputs, then advance
  task automatic model_cycle(int k);
    exp_t e;
    logic [3:0] merged, dep;
    bit gate, cond;
    mdl_t n;
    if (!reset) m[k] = mreset();
    merged = '0;
    for (int c = 0; c < 2; c++)
      if (ivld[c]) merged = merged | idata[c*4 +: 4];
    gate = !dli || (tin != 0);
    dep  = gate ? merged : m[k].dep_r;
    cond = gate && dep[0] && (proc != 0);
    e.idx = k; e.vld = proc; e.data = m[k].dep_r | 4'b0001;
    e.tok = m[k].tok; e.det = m[k].pulse; e.conf = m[k].conf;
    e.blk = m[k].blk; e.cnt = m[k].run;
    e.tv = m[k].tv; e.td = m[k].td; e.ts = m[k].ts;
    sb.push_back(e);
    if (!reset) return;
    n = m[k];
    n.dep_r = (proc != 0) ? dep : 4'b0;
    n.tok = (((tin != 0) && !tclr) || org) ? proc : 3'b0;
    n.stamp = m[k].stamp + 1;
    n.tv = m[k].pulse;
    if (m[k].pulse) begin
      n.td = dep; n.ts = m[k].stamp;
    end
    if (m[k].pulse) begin
      n.pulse = 0; n.hold = 1; n.blk = proc;
    end else if (m[k].hold) begin
      if (proc == 0) begin n.hold = 0; n.run = 0; end
    end else if (cond) begin
      n.run = m[k].run + 1;
      if (n.run == ccv[k]) begin n.pulse = 1; n.conf = 1; end
    end else begin
      n.run = 0;
    end
    m[k] = n;
  endtask

  task automatic step(logic r, logic [2:0] p, logic [1:0] v,
                      logic [7:0] d, logic [1:0] t,
                      logic dl, logic og, logic cl);
    @(posedge clock);
    #1;
    reset = r; proc = p; ivld = v; idata = d;
    tin = t; dli = dl; org = og; tclr = cl;
    model_cycle(0);
    model_cycle(1);
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t e;
      int k;
      e = sb.pop_front();
      k = e.idx;
      chk("out_vld", k, o_vld[k], e.vld);
      chk("out_data", k, o_data[k], e.data);
      chk("token_out", k, o_tok[k], e.tok);
      chk("dl_detect_out", k, o_det[k], e.det);
      chk("dl_confirmed", k, o_conf[k], e.conf);
      chk("blocked_chan", k, o_blk[k], e.blk);
      chk("stall_cnt", k, (k == 0) ? int'(cnt_a) : int'(cnt_b), e.cnt);
`ifdef PACKET_HANDLER_DL_TRACE_EN
      chk("trace_vld", k, t_vld[k], e.tv);
      chk("trace_dep", k, t_dep[k], e.td);
      chk("trace_stamp", k, t_stamp[k], e.ts);
`endif
      if (e.det) reports++;
    end
  end

  initial begin
    logic [2:0] p;
    logic [7:0] d;
    // reset, then persistent self-dependence
    repeat (2) step(0, 3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0);
    repeat (8) step(1, 3'b010, 2'b01, 8'h01, 2'b00, 0, 0, 0);
    repeat (2) step(1, 3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0);
    // one-cycle dropout restarts the count
    repeat (2) step(1, 3'b010, 2'b01, 8'h01, 2'b00, 0, 0, 0);
    step(1, 3'b010, 2'b00, 8'h01, 2'b00, 0, 0, 0);
    repeat (7) step(1, 3'b010, 2'b01, 8'h01, 2'b00, 0, 0, 0);
    repeat (2) step(1, 3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0);
    // frozen dependence under global detect without token
    step(1, 3'b010, 2'b11, 8'h02, 2'b00, 0, 0, 0);
    step(1, 3'b010, 2'b11, 8'hd1, 2'b00, 1, 0, 0);
    step(1, 3'b010, 2'b11, 8'h3d, 2'b00, 1, 0, 0);
    step(1, 3'b010, 2'b01, 8'h0f, 2'b00, 1, 0, 0);
    // token clear vs origin
    repeat (2) step(1, 3'b101, 2'b00, 8'h00, 2'b10, 0, 0, 1);
    repeat (2) step(1, 3'b110, 2'b00, 8'h00, 2'b00, 0, 1, 1);
    repeat (2) step(1, 3'b011, 2'b00, 8'h00, 2'b01, 0, 0, 0);
    // reset pulse while holding a report
    repeat (7) step(1, 3'b100, 2'b10, 8'h10, 2'b00, 0, 0, 0);
    step(0, 3'b100, 2'b10, 8'h10, 2'b00, 0, 0, 0);
    repeat (3) step(1, 3'b100, 2'b10, 8'h10, 2'b00, 0, 0, 0);
    // randomized traffic biased toward self-dependence
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 4) != 0) d = d | 8'h11;
      step(($urandom_range(0, 99) != 0), p, 2'($urandom), d,
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0));
    end
    @(negedge clock);
    #1;
    chk("sb_drained", 0, sb.size(), 0);
    if (reports == 0) begin
      failures++;
      $display("FAIL no_reports_seen act=0 exp=>0");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
